// File: rtl/sram_arbiter_pkg.sv
// sram_arbiter_pkg: shared definitions for the base-SRAM arbiter.
//   state_e  - access FSM encoding (IDLE, RD, WR, WR_HOLD, DONE)
//   owner_e  - which requester owns the transfer in flight
//   DEFAULT_WAIT_CYCLES / DEFAULT_ADDR_W - default build parameters
package sram_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    WR      = 3'd2,
    WR_HOLD = 3'd3,
    DONE    = 3'd4
  } state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  localparam int unsigned DEFAULT_WAIT_CYCLES = 2;
  localparam int unsigned DEFAULT_ADDR_W      = 20;

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: CPU-side request bus of the SRAM arbiter.
//   if_*  - instruction-fetch port (read only)
//   mem_* - data-memory port (read/write, byte enables)
// Handshake: a requester raises *_req with its address/data stable and
// holds it until the matching *_ready pulse (one cycle). It must drop
// *_req on the clock edge after *_ready, otherwise the still-high request
// is taken as a new transfer once the arbiter is back in IDLE.
//   master - the CPU side (drives requests)
//   slave  - the arbiter (drives rdata/ready)
interface sram_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_ready,
    output mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_ready,
    input  mem_req, mem_we, mem_sel, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: 4-bit strobe-width down-counter.
//   clk, rst_n  - clock, asynchronous active-low reset
//   load_i      - load load_val_i (has priority over decrement)
//   load_val_i  - value loaded on load_i
//   dec_i       - decrement by one; saturates at zero
//   zero_o      - count is zero
module sram_wait_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       dec_i,
  output logic       zero_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != 4'd0)) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == 4'd0);

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the single base SRAM bank between the fetch port and
// the data port with a registered multi-cycle access FSM.
//   clk, rst_n    - clock, asynchronous active-low reset
//   bus           - CPU request bus (slave modport): if_* and mem_* ports
//   sram_addr     - SRAM word address
//   sram_be_n     - byte enables, active low
//   sram_ce_n/oe_n/we_n - SRAM strobes, active low
//   sram_data_o   - write data to the pin buffer
//   sram_data_oe  - pin buffer drive enable
//   sram_data_i   - data sampled from the pins
//   dbg_state     - current FSM state
// Data port has fixed priority. Every SRAM-side output is a flop whose next
// value is decoded from the next state, so requests never reach the pins
// combinationally.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,  // 1..15
  parameter int unsigned ADDR_W      = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [3:0]        sram_be_n,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [31:0]       sram_data_o,
  output logic              sram_data_oe,
  input  logic [31:0]       sram_data_i,
  output state_e            dbg_state
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [3:0]        be_sel_q, be_sel_d;   // latched active-low enables
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;
  logic [31:0]       if_rdata_d, mem_rdata_d;
  logic              ce_n_d, oe_n_d, we_n_d, data_oe_d;
  logic [3:0]        be_n_d;
  logic              if_ready_d, mem_ready_d;
  logic              cnt_load, cnt_dec, cnt_zero;

  // Byte-offset and out-of-bank address bits are ignored (wrap in bank).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[1:0], bus.if_addr[31:ADDR_W+2],
                              bus.mem_addr[1:0], bus.mem_addr[31:ADDR_W+2]};

  sram_wait_counter u_wait (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (WAIT_LOAD),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    be_sel_d    = be_sel_q;
    addr_d      = sram_addr;
    wdata_d     = sram_data_o;
    if_rdata_d  = bus.if_rdata;
    mem_rdata_d = bus.mem_rdata;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.mem_req) begin
          owner_d  = OWN_MEM;
          addr_d   = bus.mem_addr[ADDR_W+1:2];
          be_sel_d = ~bus.mem_sel;
          wdata_d  = bus.mem_wdata;
          cnt_load = 1'b1;
          state_d  = bus.mem_we ? WR : RD;
        end else if (bus.if_req) begin
          owner_d  = OWN_IF;
          addr_d   = bus.if_addr[ADDR_W+1:2];
          be_sel_d = 4'h0;
          cnt_load = 1'b1;
          state_d  = RD;
        end
      end
      RD: begin
        cnt_dec = ~cnt_zero;
        if (cnt_zero) begin
          // Last strobe cycle: the pins have had the full access time.
          if (owner_q == OWN_MEM) begin
            mem_rdata_d = sram_data_i;
          end else begin
            if_rdata_d = sram_data_i;
          end
          state_d = DONE;
        end
      end
      WR: begin
        cnt_dec = ~cnt_zero;
        if (cnt_zero) begin
          state_d = WR_HOLD;
        end
      end
      WR_HOLD: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pin strobes decoded from the state being entered.
    ce_n_d      = ~((state_d == RD) || (state_d == WR) || (state_d == WR_HOLD));
    oe_n_d      = (state_d != RD);
    we_n_d      = (state_d != WR);
    data_oe_d   = (state_d == WR) || (state_d == WR_HOLD);
    be_n_d      = ce_n_d ? 4'hF : be_sel_d;
    if_ready_d  = (state_d == DONE) && (owner_d == OWN_IF);
    mem_ready_d = (state_d == DONE) && (owner_d == OWN_MEM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      owner_q       <= OWN_IF;
      be_sel_q      <= 4'hF;
      sram_addr     <= '0;
      sram_be_n     <= 4'hF;
      sram_ce_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_we_n     <= 1'b1;
      sram_data_o   <= 32'h0;
      sram_data_oe  <= 1'b0;
      bus.if_rdata  <= 32'h0;
      bus.mem_rdata <= 32'h0;
      bus.if_ready  <= 1'b0;
      bus.mem_ready <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      be_sel_q      <= be_sel_d;
      sram_addr     <= addr_d;
      sram_be_n     <= be_n_d;
      sram_ce_n     <= ce_n_d;
      sram_oe_n     <= oe_n_d;
      sram_we_n     <= we_n_d;
      sram_data_o   <= wdata_d;
      sram_data_oe  <= data_oe_d;
      bus.if_rdata  <= if_rdata_d;
      bus.mem_rdata <= mem_rdata_d;
      bus.if_ready  <= if_ready_d;
      bus.mem_ready <= mem_ready_d;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

  localparam int WC = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- DUT, WAIT_CYCLES = 2 ----------------
  sram_arbiter_if bus ();
  logic [19:0] sram_addr;
  logic [3:0]  sram_be_n;
  logic        sram_ce_n, sram_oe_n, sram_we_n, sram_data_oe;
  logic [31:0] sram_data_o, sram_data_i;
  logic [2:0]  dbg_state;

  sram_arbiter #(.WAIT_CYCLES(WC), .ADDR_W(20)) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .sram_addr    (sram_addr),
    .sram_be_n    (sram_be_n),
    .sram_ce_n    (sram_ce_n),
    .sram_oe_n    (sram_oe_n),
    .sram_we_n    (sram_we_n),
    .sram_data_o  (sram_data_o),
    .sram_data_oe (sram_data_oe),
    .sram_data_i  (sram_data_i),
    .dbg_state    (dbg_state)
  );

  // ---------------- DUT, WAIT_CYCLES = 1 ----------------
  sram_arbiter_if bus1 ();
  logic [19:0] sram_addr_1;
  logic [3:0]  sram_be_n_1;
  logic        sram_ce_n_1, sram_oe_n_1, sram_we_n_1, sram_data_oe_1;
  logic [31:0] sram_data_o_1, sram_data_i_1;
  logic [2:0]  dbg_state_1;

  sram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(20)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus1),
    .sram_addr    (sram_addr_1),
    .sram_be_n    (sram_be_n_1),
    .sram_ce_n    (sram_ce_n_1),
    .sram_oe_n    (sram_oe_n_1),
    .sram_we_n    (sram_we_n_1),
    .sram_data_o  (sram_data_o_1),
    .sram_data_oe (sram_data_oe_1),
    .sram_data_i  (sram_data_i_1),
    .dbg_state    (dbg_state_1)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_mem_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle in IDLE: everything quiet, no ready.
  task automatic idle_step();
    @(posedge clk); #1;
    chk("idle_ce_n", sram_ce_n, 1'b1);
    chk("idle_oe_n", sram_oe_n, 1'b1);
    chk("idle_we_n", sram_we_n, 1'b1);
    chk("idle_data_oe", sram_data_oe, 1'b0);
    chk("idle_be_n", sram_be_n, 4'hF);
    chk("idle_if_ready", bus.if_ready, 1'b0);
    chk("idle_mem_ready", bus.mem_ready, 1'b0);
    chk("idle_state", dbg_state, 3'd0);
  endtask

  // One transfer, called in a cycle where the DUT is IDLE (cycle 0).
  // Expected pin behaviour follows from the access rules: strobes for WC
  // cycles, one hold cycle for writes, then a single ready cycle.
  task automatic run_access(input bit is_mem, input bit we, input logic [3:0] sel,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] pin, input bit keep);
    logic [19:0] e_addr;
    logic [3:0]  e_be;
    bit          wr;
    int          ready_at;
    wr       = is_mem && we;
    e_addr   = addr[21:2];
    e_be     = is_mem ? ~sel : 4'h0;
    ready_at = wr ? WC + 2 : WC + 1;
    if (is_mem) begin
      bus.mem_req   = 1'b1;
      bus.mem_we    = we;
      bus.mem_sel   = sel;
      bus.mem_addr  = addr;
      bus.mem_wdata = wdata;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = addr;
    end
    sram_data_i = ~pin;
    for (int c = 1; c <= ready_at; c++) begin
      @(posedge clk); #1;
      if (c == ready_at) begin
        if (!wr) begin
          if (is_mem) exp_mem_rdata = pin;
          else        exp_if_rdata  = pin;
        end
        chk("done_ce_n", sram_ce_n, 1'b1);
        chk("done_oe_n", sram_oe_n, 1'b1);
        chk("done_we_n", sram_we_n, 1'b1);
        chk("done_data_oe", sram_data_oe, 1'b0);
        chk("done_be_n", sram_be_n, 4'hF);
        chk("done_if_ready", bus.if_ready, !is_mem);
        chk("done_mem_ready", bus.mem_ready, is_mem);
        chk("if_rdata", bus.if_rdata, exp_if_rdata);
        chk("mem_rdata", bus.mem_rdata, exp_mem_rdata);
        if (!keep) begin
          if (is_mem) bus.mem_req = 1'b0;
          else        bus.if_req  = 1'b0;
        end
      end else if (c <= WC) begin
        chk("acc_ce_n", sram_ce_n, 1'b0);
        chk("acc_oe_n", sram_oe_n, wr);
        chk("acc_we_n", sram_we_n, !wr);
        chk("acc_data_oe", sram_data_oe, wr);
        chk("acc_addr", sram_addr, e_addr);
        chk("acc_be_n", sram_be_n, e_be);
        chk("acc_if_ready", bus.if_ready, 1'b0);
        chk("acc_mem_ready", bus.mem_ready, 1'b0);
        if (wr) chk("acc_wdata", sram_data_o, wdata);
        // Valid data only in the last strobe cycle.
        if (c == WC) sram_data_i = pin;
      end else begin
        chk("hold_ce_n", sram_ce_n, 1'b0);
        chk("hold_oe_n", sram_oe_n, 1'b1);
        chk("hold_we_n", sram_we_n, 1'b1);
        chk("hold_data_oe", sram_data_oe, 1'b1);
        chk("hold_addr", sram_addr, e_addr);
        chk("hold_be_n", sram_be_n, e_be);
        chk("hold_wdata", sram_data_o, wdata);
        chk("hold_mem_ready", bus.mem_ready, 1'b0);
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    bit          r_mem, r_we;
    logic [3:0]  r_sel;
    logic [31:0] r_addr, r_wdata, r_pin;

    rst_n = 1'b0;
    bus.if_req = 1'b0;  bus.if_addr = '0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_sel = '0;
    bus.mem_addr = '0;  bus.mem_wdata = '0;
    bus1.if_req = 1'b0;  bus1.if_addr = '0;
    bus1.mem_req = 1'b0; bus1.mem_we = 1'b0; bus1.mem_sel = '0;
    bus1.mem_addr = '0;  bus1.mem_wdata = '0;
    sram_data_i = '0;
    sram_data_i_1 = '0;
    exp_if_rdata = '0;
    exp_mem_rdata = '0;

    // Reset values
    #12;
    chk("rst_ce_n", sram_ce_n, 1'b1);
    chk("rst_oe_n", sram_oe_n, 1'b1);
    chk("rst_we_n", sram_we_n, 1'b1);
    chk("rst_be_n", sram_be_n, 4'hF);
    chk("rst_addr", sram_addr, 20'h0);
    chk("rst_data_o", sram_data_o, 32'h0);
    chk("rst_data_oe", sram_data_oe, 1'b0);
    chk("rst_if_ready", bus.if_ready, 1'b0);
    chk("rst_mem_ready", bus.mem_ready, 1'b0);
    chk("rst_if_rdata", bus.if_rdata, 32'h0);
    chk("rst_mem_rdata", bus.mem_rdata, 32'h0);
    chk("rst_state", dbg_state, 3'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Fetch at 0x10
    run_access(1'b0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
    idle_step();
    // Data write, partial byte enables; mem_rdata stays at its old value
    run_access(1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'h1234_5678, 32'h0, 1'b0);
    idle_step();
    // Simultaneous fetch + data read: data first, fetch waits in if_req
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0040;
    run_access(1'b1, 1'b0, 4'hF, 32'h0000_0200, 32'h0, 32'hCAFE_0001, 1'b0);
    idle_step();
    run_access(1'b0, 1'b0, 4'h0, 32'h0000_0040, 32'h0, 32'hCAFE_0002, 1'b0);
    idle_step();
    // Requester keeps mem_req high through DONE: IDLE cycle, then a new access
    run_access(1'b1, 1'b0, 4'hF, 32'h0000_0300, 32'h0, 32'h5555_AAAA, 1'b1);
    idle_step();
    run_access(1'b1, 1'b0, 4'hF, 32'h0000_0300, 32'h0, 32'hAAAA_5555, 1'b0);
    idle_step();
    // Write with no byte enables
    run_access(1'b1, 1'b1, 4'h0, 32'h0000_0404, 32'hFFFF_0000, 32'h0, 1'b0);
    idle_step();
    // Upper address bits wrap within the bank
    run_access(1'b0, 1'b0, 4'h0, 32'hFFF0_0008, 32'h0, 32'h0BAD_F00D, 1'b0);
    idle_step();

    // Randomized transfers
    for (int n = 0; n < 40; n++) begin
      r_mem   = 1'($urandom_range(0, 1));
      r_we    = r_mem ? 1'($urandom_range(0, 1)) : 1'b0;
      r_sel   = 4'($urandom_range(0, 15));
      r_addr  = $urandom;
      r_wdata = $urandom;
      r_pin   = $urandom;
      run_access(r_mem, r_we, r_sel, r_addr, r_wdata, r_pin, 1'b0);
      idle_step();
    end

    // WAIT_CYCLES=1 build: back-to-back fetches at 0x0 and 0x4
    bus1.if_req   = 1'b1;
    bus1.if_addr  = 32'h0;
    sram_data_i_1 = 32'hA5A5_0001;
    @(posedge clk); #1;
    chk("w1_c1_ce_n", sram_ce_n_1, 1'b0);
    chk("w1_c1_addr", sram_addr_1, 20'h0);
    chk("w1_c1_ready", bus1.if_ready, 1'b0);
    @(posedge clk); #1;
    chk("w1_c2_ready", bus1.if_ready, 1'b1);
    chk("w1_c2_rdata", bus1.if_rdata, 32'hA5A5_0001);
    bus1.if_addr  = 32'h4;
    sram_data_i_1 = 32'hA5A5_0002;
    @(posedge clk); #1;
    chk("w1_c3_ready", bus1.if_ready, 1'b0);
    chk("w1_c3_ce_n", sram_ce_n_1, 1'b1);
    @(posedge clk); #1;
    chk("w1_c4_ce_n", sram_ce_n_1, 1'b0);
    chk("w1_c4_addr", sram_addr_1, 20'h1);
    @(posedge clk); #1;
    chk("w1_c5_ready", bus1.if_ready, 1'b1);
    chk("w1_c5_rdata", bus1.if_rdata, 32'hA5A5_0002);
    bus1.if_req = 1'b0;
    @(posedge clk); #1;
    chk("w1_idle_ready", bus1.if_ready, 1'b0);

    // Reset during the second WR cycle
    bus.mem_req   = 1'b1;
    bus.mem_we    = 1'b1;
    bus.mem_sel   = 4'hF;
    bus.mem_addr  = 32'h0000_0800;
    bus.mem_wdata = 32'h7777_8888;
    @(posedge clk); #1;
    chk("mr_c1_we_n", sram_we_n, 1'b0);
    @(posedge clk); #1;
    chk("mr_c2_we_n", sram_we_n, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_ce_n", sram_ce_n, 1'b1);
    chk("mr_we_n", sram_we_n, 1'b1);
    chk("mr_data_oe", sram_data_oe, 1'b0);
    chk("mr_be_n", sram_be_n, 4'hF);
    chk("mr_addr", sram_addr, 20'h0);
    chk("mr_mem_ready", bus.mem_ready, 1'b0);
    chk("mr_mem_rdata", bus.mem_rdata, 32'h0);
    chk("mr_if_rdata", bus.if_rdata, 32'h0);
    exp_if_rdata  = '0;
    exp_mem_rdata = '0;
    bus.mem_req = 1'b0;
    #1;
    rst_n = 1'b1;
    idle_step();
    idle_step();
    // Arbiter is usable again after the aborted transfer
    run_access(1'b0, 1'b0, 4'h0, 32'h0000_0020, 32'h0, 32'h1357_9BDF, 1'b0);
    idle_step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
